// File: rtl/add_pkg.sv
// Shared types and default sizing for the operand feeder and its FIFO.
// Sequencer states IDLE/ISSUE/WAIT/HOLD plus the wait-counter width helper.
package add_pkg;

  localparam int DEF_W       = 8;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_ADD_LAT = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Counter must hold ADD_LAT-1; keep at least one bit when ADD_LAT is 1.
  function automatic int cnt_width(input int lat);
    return (lat < 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/add_fifo.sv
// Generic FIFO: DEPTH entries of W bits, registered pointers, combinational head read.
// Latency: one cycle push-to-visible; backpressure via full, push while full is dropped.
// Pop while empty is ignored; simultaneous push and pop both take effect.
module add_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty; wraps modulo 2*DEPTH.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/add_feeder.sv
// Feeds buffered operand pairs to a multicycle serial adder; ADD_FEEDER_CHECK_EN adds res_err.
// Latency: add_en 2 cycles after push, result ADD_LAT cycles after add_en, ADD_LAT+3 per pair.
// Backpressure: in_ready low when the FIFO is full; the result is held until res_ready.
module add_feeder
  import add_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ADD_LAT = DEF_ADD_LAT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         add_en,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  input  logic [W-1:0] add_sum,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_sum,
`ifdef ADD_FEEDER_CHECK_EN
  output logic         res_err,
`endif
  output logic         busy
);

  localparam int CW = cnt_width(ADD_LAT);
  localparam int PW = 2 * W;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic            cnt_zero;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            pop;
  logic            cnt_load;
  logic            capture;
  logic            res_done;
  logic [PW-1:0]   head_dat;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign cnt_zero  = (cnt == '0);

  add_fifo #(
    .W     (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat ({in_a, in_b}),
    .pop      (pop),
    .pop_dat  (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt_zero) state_nxt = HOLD;
      HOLD:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop      = 1'b0;
    add_en   = 1'b0;
    cnt_load = 1'b0;
    capture  = 1'b0;
    res_done = 1'b0;
    busy     = (state != IDLE);
    case (state)
      IDLE:    pop = !fifo_empty;
      ISSUE: begin
        add_en   = 1'b1;
        cnt_load = 1'b1;
      end
      WAIT:    capture = cnt_zero;
      HOLD:    res_done = res_ready;
      default: ;
    endcase
  end

  // Operands only move on a pop so they stay stable for the whole add.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      add_a <= '0;
      add_b <= '0;
    end else if (pop) begin
      add_a <= head_dat[PW-1:W];
      add_b <= head_dat[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               cnt <= '0;
    else if (cnt_load)      cnt <= CW'(ADD_LAT - 1);
    else if (state == WAIT && !cnt_zero) cnt <= cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid <= 1'b0;
      res_sum   <= '0;
    end else if (capture) begin
      res_valid <= 1'b1;
      res_sum   <= add_sum;
    end else if (res_done) begin
      res_valid <= 1'b0;
    end
  end

`ifdef ADD_FEEDER_CHECK_EN
  logic [W-1:0] ref_sum;
  assign ref_sum = add_a + add_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          res_err <= 1'b0;
    else if (capture)  res_err <= (add_sum != ref_sum);
    else if (res_done) res_err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_add_feeder.sv
// Bench for add_feeder: behavioural multicycle adder plus an in-order result scoreboard.
module tb_add_feeder;

  localparam int W       = 8;
  localparam int DEPTH   = 4;
  localparam int ADD_LAT = 9;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         add_en;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic [W-1:0] add_sum = '0;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         busy;
`ifdef ADD_FEEDER_CHECK_EN
  logic         res_err;
  logic         last_err;
`endif

  typedef struct packed {
    logic [W-1:0] sum;
    logic         err;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int en_cnt = 0;
  int en_cyc = 0;
  int push_cyc = 0;
  int push_cnt = 0;
  int res_cnt = 0;
  int hs_cyc = 0;
  int max_gap = 0;
  bit gap_arm = 0;
  bit corrupt_mode = 0;
  logic [W-1:0] last_sum;

  always #5 clk = ~clk;

  add_feeder #(
    .W       (W),
    .DEPTH   (DEPTH),
    .ADD_LAT (ADD_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .add_en    (add_en),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
`ifdef ADD_FEEDER_CHECK_EN
    .res_err   (res_err),
`endif
    .busy      (busy)
  );

  // Behavioural serial adder: garbage on add_sum until the result settles ADD_LAT edges after start.
  logic [W-1:0] ab_sum;
  logic [W-1:0] mdl_val = '0;
  int           mdl_cnt = 0;
  assign ab_sum = add_a + add_b;

  always @(posedge clk) begin
    if (add_en) begin
      mdl_val <= corrupt_mode ? 8'h01 : ab_sum;
      add_sum <= ab_sum ^ 8'hA5;
      mdl_cnt <= ADD_LAT - 1;
    end else if (mdl_cnt > 0) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) add_sum <= mdl_val;
    end
  end

  // One clock: sample at negedge (scoreboard push/pop), then advance to just after the posedge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (add_en) begin
      en_cnt++;
      en_cyc = cyc;
    end
    if (in_valid && in_ready) begin
      e.sum = corrupt_mode ? 8'h01 : W'(in_a + in_b);
      e.err = corrupt_mode;
      exp_q.push_back(e);
      push_cyc = cyc;
      push_cnt++;
    end
    if (res_valid && res_ready) begin
      last_sum = res_sum;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_spurious: got res_sum=%h, required no result", res_sum);
      end else begin
        e = exp_q.pop_front();
        if (res_sum !== e.sum) begin
          bad++;
          $display("FAIL sb_sum: got res_sum=%h, required %h", res_sum, e.sum);
        end
`ifdef ADD_FEEDER_CHECK_EN
        last_err = res_err;
        total++;
        if (res_err !== e.err) begin
          bad++;
          $display("FAIL sb_err: got res_err=%b, required %b", res_err, e.err);
        end
`endif
      end
      if (gap_arm && (cyc - hs_cyc) > max_gap) max_gap = cyc - hs_cyc;
      gap_arm = 1;
      hs_cyc = cyc;
      res_cnt++;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    int n = 0;
    while (!res_valid && n < budget) begin
      tick();
      n++;
    end
    ok = res_valid;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    ok = (exp_q.size() == 0) && !busy;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({add_en, res_valid, add_a, add_b, res_sum} !== {1'b0, 1'b0, 8'h00, 8'h00, 8'h00}) begin
      bad++;
      $display("FAIL reset_regs: got en=%b rv=%b a=%h b=%h sum=%h, required all zero",
               add_en, res_valid, add_a, add_b, res_sum);
    end
    total++;
    if ({in_ready, busy} !== 2'b10) begin
      bad++;
      $display("FAIL reset_flags: got in_ready=%b busy=%b, required 1 0", in_ready, busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    int en0 = en_cnt;
    res_ready = 1'b0;
    in_valid = 1'b1;
    in_a = 8'h05;
    in_b = 8'h0A;
    tick();
    in_valid = 1'b0;
    wait_valid(60, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL basic_timeout: got res_valid=%b, required 1", res_valid);
    end
    total++;
    if (en_cyc - push_cyc != 2) begin
      bad++;
      $display("FAIL basic_en_delay: got %0d cycles, required 2", en_cyc - push_cyc);
    end
    total++;
    if (cyc - (en_cyc + 1) != ADD_LAT) begin
      bad++;
      $display("FAIL basic_lat: got %0d cycles, required %0d", cyc - (en_cyc + 1), ADD_LAT);
    end
    total++;
    if (res_sum !== 8'h0F) begin
      bad++;
      $display("FAIL basic_sum: got %h, required 0f", res_sum);
    end
    total++;
    if (en_cnt - en0 != 1) begin
      bad++;
      $display("FAIL basic_en_count: got %0d pulses, required 1", en_cnt - en0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    tick();
    total++;
    if ({res_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL basic_release: got rv=%b busy=%b, required 0 0", res_valid, busy);
    end
  endtask

  task automatic test_full();
    bit ok;
    int p0;
    int r0;
    res_ready = 1'b0;
    in_valid = 1'b1;
    in_a = 8'h10;
    in_b = 8'h01;
    tick();
    in_valid = 1'b0;
    wait_valid(60, ok);
    p0 = push_cnt;
    r0 = res_cnt;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_a = 8'h20 + 8'(i);
      in_b = 8'h03 * 8'(i + 1);
      tick();
    end
    in_a = 8'h77;
    in_b = 8'h77;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_in_ready: got %b, required 0", in_ready);
    end
    repeat (3) tick();
    in_valid = 1'b0;
    total++;
    if (push_cnt - p0 != DEPTH) begin
      bad++;
      $display("FAIL full_accepted: got %0d, required %0d", push_cnt - p0, DEPTH);
    end
    res_ready = 1'b1;
    wait_drain((DEPTH + 1) * (ADD_LAT + 3) + 20, ok);
    repeat (15) tick();
    total++;
    if (!ok || res_cnt - r0 != DEPTH + 1) begin
      bad++;
      $display("FAIL full_drain: got %0d results, required %0d", res_cnt - r0, DEPTH + 1);
    end
  endtask

  task automatic test_wrap_sum();
    bit ok;
    res_ready = 1'b1;
    in_valid = 1'b1;
    in_a = 8'hFF;
    in_b = 8'h01;
    tick();
    in_valid = 1'b0;
    wait_drain(60, ok);
    total++;
    if (!ok || last_sum !== 8'h00) begin
      bad++;
      $display("FAIL wrap_sum: got %h, required 00", last_sum);
    end
`ifdef ADD_FEEDER_CHECK_EN
    corrupt_mode = 1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_drain(60, ok);
    corrupt_mode = 0;
    total++;
    if (!ok || last_err !== 1'b1 || last_sum !== 8'h01) begin
      bad++;
      $display("FAIL check_err: got err=%b sum=%h, required 1 01", last_err, last_sum);
    end
    total++;
    if (res_err !== 1'b0) begin
      bad++;
      $display("FAIL check_err_clear: got %b, required 0", res_err);
    end
`endif
  endtask

  task automatic test_hold();
    bit ok;
    bit stable = 1;
    int en0;
    logic [W-1:0] s;
    res_ready = 1'b0;
    in_valid = 1'b1;
    in_a = 8'h21;
    in_b = 8'h12;
    tick();
    in_valid = 1'b0;
    wait_valid(60, ok);
    in_valid = 1'b1;
    in_a = 8'h01;
    in_b = 8'h02;
    tick();
    in_valid = 1'b0;
    s = res_sum;
    en0 = en_cnt;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (res_sum !== s || res_valid !== 1'b1 || busy !== 1'b1) stable = 0;
    end
    total++;
    if (!ok || s !== 8'h33) begin
      bad++;
      $display("FAIL hold_sum: got %h, required 33", s);
    end
    total++;
    if (!stable) begin
      bad++;
      $display("FAIL hold_stable: got sum=%h rv=%b busy=%b, required %h 1 1", res_sum, res_valid, busy, s);
    end
    total++;
    if (en_cnt != en0) begin
      bad++;
      $display("FAIL hold_no_en: got %0d pulses, required 0", en_cnt - en0);
    end
    res_ready = 1'b1;
    wait_drain(80, ok);
  endtask

  task automatic test_reset_mid();
    int en0;
    int r0;
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a = 8'h40 + 8'(i);
      in_b = 8'h05;
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    total++;
    if (busy !== 1'b1 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_pre: got busy=%b rv=%b, required 1 0", busy, res_valid);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({in_ready, busy, add_en, res_valid, add_a, add_b, res_sum} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00}) begin
      bad++;
      $display("FAIL mid_reset: got rdy=%b busy=%b en=%b rv=%b a=%h b=%h sum=%h, required 1 0 0 0 0 0 0",
               in_ready, busy, add_en, res_valid, add_a, add_b, res_sum);
    end
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b1;
    en0 = en_cnt;
    r0 = res_cnt;
    repeat (40) tick();
    total++;
    if (en_cnt != en0 || res_cnt != r0) begin
      bad++;
      $display("FAIL mid_after: got en=%0d res=%0d, required 0 0", en_cnt - en0, res_cnt - r0);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int p0 = push_cnt;
    int r0 = res_cnt;
    int n = 0;
    res_ready = 1'b1;
    gap_arm = 0;
    max_gap = 0;
    in_a = W'($urandom_range(0, 255));
    in_b = W'($urandom_range(0, 255));
    while (push_cnt - p0 < 12 && n < 12 * (ADD_LAT + 3) + 60) begin
      in_valid = 1'b1;
      tick();
      if (push_cnt != p0 && push_cyc == cyc - 1) begin
        in_a = W'($urandom_range(0, 255));
        in_b = W'($urandom_range(0, 255));
      end
      n++;
    end
    in_valid = 1'b0;
    wait_drain(8 * (ADD_LAT + 3), ok);
    total++;
    if (!ok || res_cnt - r0 != 12) begin
      bad++;
      $display("FAIL b2b_count: got %0d results, required 12", res_cnt - r0);
    end
    total++;
    if (max_gap != ADD_LAT + 3) begin
      bad++;
      $display("FAIL b2b_gap: got %0d cycles, required %0d", max_gap, ADD_LAT + 3);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_wrap_sum();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
